// File: rtl/instr_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pkg_instr_fetch
// Brief   : Shared types and constants for the instruction fetch sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package pkg_instr_fetch;

   typedef enum logic [2:0] {
      S_W0_LO = 3'd0,
      S_W0_HI = 3'd1,
      S_CHECK = 3'd2,
      S_W1_LO = 3'd3,
      S_W1_HI = 3'd4,
      S_ISSUE = 3'd5
   } instr_fetch_state_t;

   localparam int          INSTR_WORD_WIDTH = 16;
   localparam int          MEM_DATA_WIDTH   = 8;
   localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_ctrl_if
// Brief   : Memory-bus, decoder and execute-stage signals of the fetch sequencer.
// Rev     : 1.0  initial release
// ============================================================================
interface instr_fetch_ctrl_if
   import pkg_instr_fetch::*;
#(
   parameter int ADDR_WIDTH = 16
);
   logic                        mem_req;
   logic [ADDR_WIDTH-1:0]       mem_addr;
   logic                        mem_ack;
   logic [MEM_DATA_WIDTH-1:0]   mem_rdata;
   logic                        hold;
   logic [INSTR_WORD_WIDTH-1:0] dec_instr;
   logic [INSTR_WORD_WIDTH-1:0] dec_ext;
   logic                        dec_needs_ext;
   logic                        dec_valid;
   logic                        exec_done;
   logic                        branch_taken;
   logic [ADDR_WIDTH-1:0]       branch_target;
   logic [ADDR_WIDTH-1:0]       pc;

   modport master (
      output mem_req, mem_addr, dec_instr, dec_ext, dec_valid, pc,
      input  mem_ack, mem_rdata, hold, dec_needs_ext, exec_done,
             branch_taken, branch_target
   );

   modport slave (
      input  mem_req, mem_addr, dec_instr, dec_ext, dec_valid, pc,
      output mem_ack, mem_rdata, hold, dec_needs_ext, exec_done,
             branch_taken, branch_target
   );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_ctrl
// Brief   : Fetches 16-bit instructions (plus optional extension word) as byte
//           reads, issues them to decode/execute and owns the program counter.
// Rev     : 1.0  initial release
// ============================================================================
module instr_fetch_ctrl
   import pkg_instr_fetch::*;
#(
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
   input  wire logic          clk,
   input  wire logic          reset_n,
   instr_fetch_ctrl_if.master bus
);

   instr_fetch_state_t          r_state;
   instr_fetch_state_t          w_state_nxt;
   logic                        r_req;
   logic                        w_req_nxt;
   logic                        w_dec_valid;
   logic                        w_ack;
   logic                        w_retire;
   logic [ADDR_WIDTH-1:0]       r_pc;
   logic [ADDR_WIDTH-1:0]       r_fetch_addr;
   logic [INSTR_WORD_WIDTH-1:0] r_instr;
   logic [INSTR_WORD_WIDTH-1:0] r_ext;

   assign w_ack    = r_req & bus.mem_ack;
   assign w_retire = (r_state == S_ISSUE) & bus.exec_done;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_W0_LO;
         r_req   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_req   <= w_req_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_W0_LO: if (w_ack) w_state_nxt = S_W0_HI;
         S_W0_HI: if (w_ack) w_state_nxt = S_CHECK;
         S_CHECK: w_state_nxt = bus.dec_needs_ext ? S_W1_LO : S_ISSUE;
         S_W1_LO: if (w_ack) w_state_nxt = S_W1_HI;
         S_W1_HI: if (w_ack) w_state_nxt = S_ISSUE;
         S_ISSUE: if (bus.exec_done) w_state_nxt = S_W0_LO;
         default: w_state_nxt = S_W0_LO;
      endcase
   end

   // mem_req is registered, so hold is sampled one edge ahead of the request
   // it gates; a request already raised stays up until acknowledged.
   always_comb begin
      w_dec_valid = (r_state == S_ISSUE);
      w_req_nxt   = 1'b0;
      case (w_state_nxt)
         S_W0_LO: w_req_nxt = ((r_state == S_W0_LO) && r_req) ? 1'b1 : ~bus.hold;
         S_W0_HI,
         S_W1_LO,
         S_W1_HI: w_req_nxt = 1'b1;
         default: w_req_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_pc         <= RESET_PC;
         r_fetch_addr <= RESET_PC;
         r_instr      <= '0;
         r_ext        <= '0;
      end else begin
         if (w_ack) begin
            r_fetch_addr <= r_fetch_addr + 1'b1;
            case (r_state)
               S_W0_LO: r_instr[MEM_DATA_WIDTH-1:0]                <= bus.mem_rdata;
               S_W0_HI: r_instr[INSTR_WORD_WIDTH-1:MEM_DATA_WIDTH] <= bus.mem_rdata;
               S_W1_LO: r_ext[MEM_DATA_WIDTH-1:0]                  <= bus.mem_rdata;
               S_W1_HI: r_ext[INSTR_WORD_WIDTH-1:MEM_DATA_WIDTH]   <= bus.mem_rdata;
               default: ;
            endcase
         end
         if ((r_state == S_CHECK) && !bus.dec_needs_ext) begin
            r_ext <= '0;
         end
         if (w_retire) begin
            if (bus.branch_taken) begin
               r_pc         <= bus.branch_target;
               r_fetch_addr <= bus.branch_target;
            end else begin
               r_pc <= r_fetch_addr;
            end
         end
      end
   end

   assign bus.mem_req   = r_req;
   assign bus.mem_addr  = r_fetch_addr;
   assign bus.dec_instr = r_instr;
   assign bus.dec_ext   = r_ext;
   assign bus.dec_valid = w_dec_valid;
   assign bus.pc        = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_fetch_ctrl
// Brief   : Randomized self-checking bench with a byte-memory responder and an
//           instruction-level reference model of PC / fetch behaviour.
// Rev     : 1.0  initial release
// ============================================================================
module tb_instr_fetch_ctrl;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   instr_fetch_ctrl_if #(.ADDR_WIDTH(16)) bus ();

   instr_fetch_ctrl #(
      .ADDR_WIDTH(16),
      .RESET_PC  (16'h0000)
   ) u_dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   // Stand-in decoder: bit 15 of the first word marks a two-word instruction.
   assign bus.dec_needs_ext = bus.dec_instr[15];

   logic [7:0]  mem [0:65535];
   logic [15:0] addr_log[$];
   logic [15:0] req_addr;
   logic [15:0] m_pc;
   int          n_checks = 0;
   int          n_errors = 0;
   bit          resp_en  = 1'b1;
   bit          inj_ack  = 1'b0;
   bit          noise_en = 1'b0;
   bit          lat_rand = 1'b0;
   int          lat_cfg  = 0;
   int          wait_cnt = 0;
   int          cur_lat  = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Byte-memory responder with configurable wait states; acks with no
   // request pending are sprayed as noise the DUT must ignore.
   always @(negedge clk) begin
      if (!resp_en) begin
         wait_cnt      = 0;
         bus.mem_ack   = inj_ack;
         bus.mem_rdata = 8'hEE;
      end else if (bus.mem_req) begin
         if (wait_cnt == 0) begin
            cur_lat  = lat_rand ? int'($urandom_range(0, 3)) : lat_cfg;
            req_addr = bus.mem_addr;
         end else begin
            check_eq("addr_stable", bus.mem_addr, req_addr);
         end
         if (wait_cnt >= cur_lat) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem[bus.mem_addr];
            addr_log.push_back(bus.mem_addr);
            wait_cnt      = 0;
         end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 8'($urandom);
            wait_cnt++;
         end
      end else begin
         wait_cnt      = 0;
         bus.mem_ack   = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.mem_rdata = 8'($urandom);
      end
   end

   task automatic run_instr(input bit do_br, input logic [15:0] tgt, input bit chk_lat);
      int          cyc;
      int          extra;
      int          nbytes;
      logic [15:0] e_instr;
      logic [15:0] e_ext;
      logic [15:0] a;
      cyc = 0;
      while (!bus.dec_valid && cyc < 200) begin
         bus.exec_done     = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.branch_taken  = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.branch_target = 16'($urandom);
         @(posedge clk); #1;
         cyc++;
      end
      bus.exec_done    = 1'b0;
      bus.branch_taken = 1'b0;
      check_eq("dec_valid", bus.dec_valid, 1);
      e_instr = {mem[m_pc + 16'd1], mem[m_pc]};
      nbytes  = e_instr[15] ? 4 : 2;
      e_ext   = e_instr[15] ? {mem[m_pc + 16'd3], mem[m_pc + 16'd2]} : 16'h0000;
      check_eq("dec_instr", bus.dec_instr, e_instr);
      check_eq("dec_ext", bus.dec_ext, e_ext);
      check_eq("pc_issue", bus.pc, m_pc);
      if (chk_lat) check_eq("latency", cyc, (nbytes == 4) ? 5 : 3);
      check_eq("req_count", addr_log.size(), nbytes);
      for (int i = 0; i < nbytes && i < addr_log.size(); i++) begin
         a = m_pc + 16'(i);
         check_eq("mem_addr_seq", addr_log[i], a);
      end
      extra = $urandom_range(0, 2);
      repeat (extra) begin
         @(posedge clk); #1;
         check_eq("valid_held", bus.dec_valid, 1);
         check_eq("instr_stable", bus.dec_instr, e_instr);
      end
      bus.exec_done     = 1'b1;
      bus.branch_taken  = do_br;
      bus.branch_target = do_br ? tgt : 16'($urandom);
      @(posedge clk); #1;
      bus.exec_done    = 1'b0;
      bus.branch_taken = 1'b0;
      m_pc = do_br ? tgt : m_pc + 16'(nbytes);
      addr_log.delete();
      check_eq("valid_drop", bus.dec_valid, 0);
      check_eq("pc_retire", bus.pc, m_pc);
      check_eq("addr_retire", bus.mem_addr, m_pc);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12;
      mem[16'h0010] = 8'h01; mem[16'h0011] = 8'h80;
      mem[16'h0012] = 8'hCD; mem[16'h0013] = 8'hAB;
      mem[16'hFFFF] = mem[16'hFFFF] | 8'h80;

      reset_n           = 1'b0;
      bus.hold          = 1'b0;
      bus.exec_done     = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_mem_req", bus.mem_req, 0);
      check_eq("rst_dec_valid", bus.dec_valid, 0);
      check_eq("rst_pc", bus.pc, 16'h0000);
      check_eq("rst_dec_instr", bus.dec_instr, 16'h0000);
      check_eq("rst_dec_ext", bus.dec_ext, 16'h0000);

      reset_n = 1'b1;
      addr_log.delete();
      m_pc = 16'h0000;
      @(posedge clk); #1;
      check_eq("req_after_rst", bus.mem_req, 1);
      run_instr(1'b1, 16'h0010, 1'b1);
      run_instr(1'b0, 16'h0000, 1'b1);
      run_instr(1'b1, 16'h0200, 1'b1);

      noise_en = 1'b1;
      lat_rand = 1'b1;
      for (int k = 0; k < 30; k++) begin
         run_instr(($urandom_range(0, 3) == 0), 16'($urandom), 1'b0);
      end

      noise_en = 1'b0;
      lat_rand = 1'b0;
      lat_cfg  = 0;
      run_instr(1'b1, 16'hFFFE, 1'b1);
      lat_cfg = 3;
      run_instr(1'b0, 16'h0000, 1'b0);

      noise_en = 1'b1;
      run_instr(1'b0, 16'h0000, 1'b0);
      bus.hold = 1'b1;
      check_eq("hold_mid_req", bus.mem_req, 1);
      run_instr(1'b0, 16'h0000, 1'b0);
      for (int k = 0; k < 5; k++) begin
         check_eq("hold_no_req", bus.mem_req, 0);
         @(posedge clk); #1;
      end
      bus.hold = 1'b0;
      @(posedge clk); #1;
      check_eq("hold_release_req", bus.mem_req, 1);
      lat_cfg = 10;
      run_instr(1'b0, 16'h0000, 1'b0);

      @(posedge clk); #1;
      check_eq("pending_req", bus.mem_req, 1);
      reset_n = 1'b0;
      @(posedge clk); #1;
      check_eq("midrst_mem_req", bus.mem_req, 0);
      check_eq("midrst_dec_valid", bus.dec_valid, 0);
      check_eq("midrst_pc", bus.pc, 16'h0000);
      resp_en = 1'b0;
      inj_ack = 1'b1;
      reset_n = 1'b1;
      lat_cfg = 0;
      @(posedge clk); #1;
      check_eq("late_ack_instr", bus.dec_instr, 16'h0000);
      resp_en = 1'b1;
      inj_ack = 1'b0;
      addr_log.delete();
      m_pc = 16'h0000;
      run_instr(1'b0, 16'h0000, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
